// File: rtl/fetch_stage_if.sv
// fetch_stage_if: debug/decode-facing control, load and instruction signals of the fetch stage
interface fetch_stage_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 8
);
  logic                   valid;
  logic                   execution_mode;
  logic                   step;
  logic                   start;
  logic                   restart;
  logic                   load_en;
  logic [NB_MEM_ADDR-1:0] load_addr;
  logic [NB_DATA-1:0]     load_data;
  logic                   stall;
  logic                   jump_taken;
  logic [NB_DATA-1:0]     pc_jump;
  logic [NB_DATA-1:0]     instruction;
  logic [NB_DATA-1:0]     pc_next;
  logic                   halt;
  logic                   running;
  logic [NB_DATA-1:0]     fetch_count;
  modport master (
    input  valid, execution_mode, step, start, restart, load_en, load_addr, load_data,
    input  stall, jump_taken, pc_jump,
    output instruction, pc_next, halt, running, fetch_count
  );
  modport slave (
    output valid, execution_mode, step, start, restart, load_en, load_addr, load_data,
    output stall, jump_taken, pc_jump,
    input  instruction, pc_next, halt, running, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS fetch with PC, word-addressed instruction memory and IDLE/RUN/HALTED control.
// Optional FETCH_STAGE_FETCH_COUNT_EN builds the fetch counter; otherwise fetch_count is 0.
module fetch_stage #(
  parameter int                 NB_DATA     = 32,
  parameter int                 NB_MEM_ADDR = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2;
  logic [1:0]         state;
  logic [NB_DATA-1:0] pc, word;
  logic [NB_DATA-1:0] mem [2**NB_MEM_ADDR];
  logic               advance, is_halt, restart;
  always_comb begin
    word    = mem[pc[NB_MEM_ADDR+1:2]];
    is_halt = word == HALT_WORD;
    advance = state == RUN && bus.valid && !bus.stall && (!bus.execution_mode || bus.step);
    restart = state == HALTED && bus.valid && bus.restart;
  end
  always_ff @(posedge clk)
    if (state == IDLE && bus.load_en) mem[bus.load_addr] <= bus.load_data;
  // a halt freezes pc at its own address and discards any coincident redirect
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      pc              <= '0;
      bus.instruction <= '0;
      bus.pc_next     <= '0;
      bus.halt        <= 1'b0;
    end else if (bus.valid) begin
      if (state == IDLE && bus.start) state <= RUN;
      if (advance) begin
        bus.instruction <= word;
        bus.pc_next     <= pc + NB_DATA'(4);
        bus.halt        <= is_halt;
        state           <= is_halt ? HALTED : RUN;
        pc              <= is_halt ? pc : bus.jump_taken ? bus.pc_jump : pc + NB_DATA'(4);
      end
      if (restart) begin
        state           <= IDLE;
        pc              <= '0;
        bus.instruction <= '0;
        bus.pc_next     <= '0;
        bus.halt        <= 1'b0;
      end
    end
  assign bus.running = state == RUN;
`ifdef FETCH_STAGE_FETCH_COUNT_EN
  logic [NB_DATA-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (advance) count <= count + NB_DATA'(1);
  assign bus.fetch_count = count;
`else
  assign bus.fetch_count = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against a behavioural model
module tb_fetch_stage;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fetch_stage_if #(.NB_DATA(32), .NB_MEM_ADDR(8)) bus();
  fetch_stage #(.NB_DATA(32), .NB_MEM_ADDR(8), .HALT_WORD(HALT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] instr, pcn, cnt;
    logic        halt, running;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;

  logic [31:0] mmem [256];
  logic [31:0] mpc, minstr, mpcn, mcnt;
  logic        mhalt;
  int          mst;

  function automatic logic [31:0] exp_cnt();
`ifdef FETCH_STAGE_FETCH_COUNT_EN
    return mcnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    mst = 0; mpc = 0; minstr = 0; mpcn = 0; mhalt = 0; mcnt = 0;
  endtask

  task automatic model_clear_outputs();
    mpc = 0; minstr = 0; mpcn = 0; mhalt = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // one clock: predict the post-edge outputs from the inputs currently driven, then let the edge happen
  task automatic tick();
    logic [31:0] w;
    bit go;
    go = mst == 1 && bus.valid && !bus.stall && (!bus.execution_mode || bus.step);
    if (mst == 0 && bus.load_en) mmem[bus.load_addr] = bus.load_data;
    if (bus.valid) begin
      if (mst == 0) begin
        if (bus.start) mst = 1;
      end else if (mst == 1) begin
        if (go) begin
          w = mmem[(mpc / 4) % 256];
          minstr = w; mpcn = mpc + 4; mhalt = w == HALT; mcnt = mcnt + 1;
          if (w == HALT) mst = 2;
          else mpc = bus.jump_taken ? bus.pc_jump : mpc + 4;
        end
      end else if (bus.restart) begin
        mst = 0;
        model_clear_outputs();
      end
    end
    sb.push_back('{minstr, mpcn, exp_cnt(), mhalt, mst == 1});
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.valid = 1; bus.execution_mode = 0; bus.step = 0; bus.start = 0; bus.restart = 0;
    bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0; bus.stall = 0;
    bus.jump_taken = 0; bus.pc_jump = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " instruction"}, bus.instruction, 32'h0);
    chk({tag, " pc_next"}, bus.pc_next, 32'h0);
    chk({tag, " halt"}, 32'(bus.halt), 32'h0);
    chk({tag, " running"}, 32'(bus.running), 32'h0);
    chk({tag, " fetch_count"}, bus.fetch_count, 32'h0);
  endtask

  task automatic run_first_program(input string tag);
    bus.start = 1; tick(); bus.start = 0;
    repeat (4) tick();
    chk({tag, " instruction"}, bus.instruction, HALT);
    chk({tag, " pc_next"}, bus.pc_next, 32'd12);
    chk({tag, " halt"}, 32'(bus.halt), 32'h1);
    chk({tag, " running"}, 32'(bus.running), 32'h0);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (bus.instruction !== e.instr || bus.pc_next !== e.pcn || bus.halt !== e.halt ||
          bus.running !== e.running || bus.fetch_count !== e.cnt) begin
        miscompares++;
        $display("FAIL vector %0d: got instr=%h pc_next=%h halt=%b running=%b count=%h, required instr=%h pc_next=%h halt=%b running=%b count=%h",
                 vectors, bus.instruction, bus.pc_next, bus.halt, bus.running, bus.fetch_count,
                 e.instr, e.pcn, e.halt, e.running, e.cnt);
      end
    end
  end

  initial begin
    quiet();
    rst = 1;
    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      bus.load_en = 1; bus.load_addr = 8'(i);
      bus.load_data = i < 2 ? 32'h2000_0001 + 32'(i) : i == 2 ? HALT : $urandom & 32'h7FFF_FFFF;
      tick();
    end
    bus.load_en = 0;
    run_first_program("prog");
`ifdef FETCH_STAGE_FETCH_COUNT_EN
    chk("prog fetch_count", bus.fetch_count, 32'd3);
`else
    chk("prog fetch_count", bus.fetch_count, 32'd0);
`endif
    bus.restart = 1; tick(); bus.restart = 0;
    chk("restart running", 32'(bus.running), 32'h0);
    chk("restart instruction", bus.instruction, 32'h0);
    run_first_program("rerun");
    // replace the halt at word 2 so the following tests run freely
    bus.restart = 1; tick(); bus.restart = 0;
    bus.load_en = 1; bus.load_addr = 8'd2; bus.load_data = 32'h2000_0003; tick();
    bus.load_en = 0;
    bus.start = 1; tick(); bus.start = 0;
    repeat (2) tick();
    bus.stall = 1; repeat (2) tick(); bus.stall = 0;
    repeat (2) tick();
    chk("stall resume pc_next", bus.pc_next, 32'd16);
    // load attempt during RUN at the word about to be fetched
    bus.load_en = 1; bus.load_addr = 8'((mpc / 4) % 256); bus.load_data = 32'h1234_5678; tick();
    bus.load_en = 0; tick();
    // reset mid-run
    rst = 1;
    #1;
    check_zero_outputs("async reset");
    model_reset();
    @(negedge clk);
    rst = 0;
    bus.start = 1; tick(); bus.start = 0;
    tick();
    bus.jump_taken = 1; bus.pc_jump = 32'h40; tick();
    bus.jump_taken = 0;
    chk("delay slot pc_next", bus.pc_next, 32'h8);
    tick();
    chk("jump target pc_next", bus.pc_next, 32'h44);
    chk("jump target instruction", bus.instruction, mmem[16]);
    bus.execution_mode = 1;
    for (int k = 0; k < 3; k++) begin
      bus.step = 1; bus.stall = k == 1; tick();
      bus.step = 0; bus.stall = 0;
      repeat (5) tick();
    end
    chk("step pc_next", bus.pc_next, 32'h4C);
    bus.execution_mode = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.valid = $urandom_range(7) != 0;
      bus.stall = $urandom_range(4) == 0;
      bus.execution_mode = $urandom_range(3) == 0;
      bus.step = $urandom_range(1);
      bus.jump_taken = $urandom_range(5) == 0;
      bus.pc_jump = $urandom_range(7) == 0 ? $urandom : $urandom & 32'h3FF;
      bus.load_en = $urandom_range(2) == 0;
      bus.load_addr = 8'($urandom);
      bus.load_data = $urandom_range(3) == 0 ? HALT : $urandom & 32'h7FFF_FFFF;
      bus.start = $urandom_range(mst == 0 ? 5 : 9) == 0;
      bus.restart = $urandom_range(mst == 2 ? 3 : 9) == 0;
      tick();
    end
    quiet();
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
